// File: rtl/video_timing_pkg.sv
// Shared types, XGA defaults and timing helpers for the video timing generator.
package video_timing_pkg;

    localparam int unsigned TIM_W = 13;
    localparam int unsigned SUM_W = TIM_W + 2;

    typedef struct packed {
        logic [TIM_W-1:0] active;
        logic [TIM_W-1:0] fporch;
        logic [TIM_W-1:0] sync;
        logic [TIM_W-1:0] bporch;
    } timing_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } vtg_state_t;

    // XGA 1024x768 @ 60 Hz
    localparam int unsigned XGA_H_ACTIVE = 1024;
    localparam int unsigned XGA_H_FPORCH = 24;
    localparam int unsigned XGA_H_SYNC   = 136;
    localparam int unsigned XGA_H_BPORCH = 160;
    localparam int unsigned XGA_V_ACTIVE = 768;
    localparam int unsigned XGA_V_FPORCH = 3;
    localparam int unsigned XGA_V_SYNC   = 6;
    localparam int unsigned XGA_V_BPORCH = 29;

    localparam logic [SUM_W-1:0] SPAN_MAX = SUM_W'(1) << TIM_W;

    function automatic logic [SUM_W-1:0] timing_span(input timing_t t);
        return SUM_W'(t.active) + SUM_W'(t.fporch) + SUM_W'(t.sync) + SUM_W'(t.bporch);
    endfunction

    // Active and sync must be non-empty; the total must fit the counter range.
    function automatic logic timing_valid(input timing_t t);
        return (t.active != '0) && (t.sync != '0) && (timing_span(t) <= SPAN_MAX);
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One counter axis: next-count, wrap detect and active/sync decode of the next count.
module timing_axis
    import video_timing_pkg::*;
(
    input  logic [TIM_W-1:0] count,
    input  logic             step,
    input  logic             restart,
    input  timing_t          tim,
    input  logic             pol,
    output logic [TIM_W-1:0] count_nxt_c,
    output logic             at_last_c,
    output logic             in_active_c,
    output logic             in_sync_c
);

    logic [SUM_W-1:0] span_c;
    logic [SUM_W-1:0] sync_lo_c;
    logic [SUM_W-1:0] sync_hi_c;
    logic [SUM_W-1:0] nxt_w_c;

    always_comb begin
        span_c    = timing_span(tim);
        sync_lo_c = SUM_W'(tim.active) + SUM_W'(tim.fporch);
        sync_hi_c = sync_lo_c + SUM_W'(tim.sync);
        at_last_c = (SUM_W'(count) == (span_c - SUM_W'(1)));

        count_nxt_c = count;
        if (restart || (step && at_last_c)) begin
            count_nxt_c = '0;
        end else if (step) begin
            count_nxt_c = count + TIM_W'(1);
        end

        // Decode describes the count about to be registered, not the current one.
        nxt_w_c     = SUM_W'(count_nxt_c);
        in_active_c = (nxt_w_c < SUM_W'(tim.active));
        in_sync_c   = ((nxt_w_c >= sync_lo_c) && (nxt_w_c < sync_hi_c)) ? pol : ~pol;
    end

endmodule

// File: rtl/video_timing_gen.sv
// Runtime-programmable sync/position generator; staged timing is applied only at frame start.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned W        = TIM_W,
    parameter int unsigned H_ACTIVE = XGA_H_ACTIVE,
    parameter int unsigned H_FPORCH = XGA_H_FPORCH,
    parameter int unsigned H_SYNC   = XGA_H_SYNC,
    parameter int unsigned H_BPORCH = XGA_H_BPORCH,
    parameter int unsigned V_ACTIVE = XGA_V_ACTIVE,
    parameter int unsigned V_FPORCH = XGA_V_FPORCH,
    parameter int unsigned V_SYNC   = XGA_V_SYNC,
    parameter int unsigned V_BPORCH = XGA_V_BPORCH,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CE,
    input  logic         CFG_LOAD,
    input  logic [W-1:0] CFG_H_ACTIVE,
    input  logic [W-1:0] CFG_H_FPORCH,
    input  logic [W-1:0] CFG_H_SYNC,
    input  logic [W-1:0] CFG_H_BPORCH,
    input  logic [W-1:0] CFG_V_ACTIVE,
    input  logic [W-1:0] CFG_V_FPORCH,
    input  logic [W-1:0] CFG_V_SYNC,
    input  logic [W-1:0] CFG_V_BPORCH,
    output logic         CFG_PENDING,
    output logic         CFG_ERR,
    output logic         HSYNC,
    output logic         VSYNC,
    output logic         ACTIVE,
    output logic         LINE_START,
    output logic         FRAME_START,
    output logic [W-1:0] h,
    output logic [W-1:0] v
);

    localparam timing_t DEF_H = '{active: TIM_W'(H_ACTIVE), fporch: TIM_W'(H_FPORCH),
                                  sync:   TIM_W'(H_SYNC),   bporch: TIM_W'(H_BPORCH)};
    localparam timing_t DEF_V = '{active: TIM_W'(V_ACTIVE), fporch: TIM_W'(V_FPORCH),
                                  sync:   TIM_W'(V_SYNC),   bporch: TIM_W'(V_BPORCH)};

    vtg_state_t state, state_nxt;
    timing_t    live_h, live_v, pend_h, pend_v;
    timing_t    cfg_h_c, cfg_v_c;
    logic       cfg_ok_c;

    logic             advance_c, start_c, apply_c, h_step_c, v_step_c;
    logic [TIM_W-1:0] h_nxt_c, v_nxt_c;
    logic             h_last_c, v_last_c;
    logic             h_act_c, v_act_c, h_sync_c, v_sync_c;

    always_comb begin
        cfg_h_c  = '{active: TIM_W'(CFG_H_ACTIVE), fporch: TIM_W'(CFG_H_FPORCH),
                     sync:   TIM_W'(CFG_H_SYNC),   bporch: TIM_W'(CFG_H_BPORCH)};
        cfg_v_c  = '{active: TIM_W'(CFG_V_ACTIVE), fporch: TIM_W'(CFG_V_FPORCH),
                     sync:   TIM_W'(CFG_V_SYNC),   bporch: TIM_W'(CFG_V_BPORCH)};
        cfg_ok_c = timing_valid(cfg_h_c) && timing_valid(cfg_v_c);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        advance_c = 1'b0;
        start_c   = 1'b0;
        apply_c   = 1'b0;
        h_step_c  = 1'b0;
        v_step_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (CE) begin
                    state_nxt = S_RUN;
                    advance_c = 1'b1;
                    start_c   = 1'b1;
                    apply_c   = 1'b1;
                end
            end
            S_RUN: begin
                if (CE) begin
                    advance_c = 1'b1;
                    h_step_c  = 1'b1;
                    v_step_c  = h_last_c;
                    apply_c   = h_last_c && v_last_c;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Decoding with live timing is safe on apply: (0,0) decodes the same under any valid timing.
    timing_axis u_h_axis (
        .count       (TIM_W'(h)),
        .step        (h_step_c),
        .restart     (start_c),
        .tim         (live_h),
        .pol         (H_POL),
        .count_nxt_c (h_nxt_c),
        .at_last_c   (h_last_c),
        .in_active_c (h_act_c),
        .in_sync_c   (h_sync_c)
    );

    timing_axis u_v_axis (
        .count       (TIM_W'(v)),
        .step        (v_step_c),
        .restart     (start_c),
        .tim         (live_v),
        .pol         (V_POL),
        .count_nxt_c (v_nxt_c),
        .at_last_c   (v_last_c),
        .in_active_c (v_act_c),
        .in_sync_c   (v_sync_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            h           <= '0;
            v           <= '0;
            ACTIVE      <= 1'b0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
            HSYNC       <= ~H_POL;
            VSYNC       <= ~V_POL;
            CFG_PENDING <= 1'b0;
            CFG_ERR     <= 1'b0;
            live_h      <= DEF_H;
            live_v      <= DEF_V;
            pend_h      <= DEF_H;
            pend_v      <= DEF_V;
        end else begin
            CFG_ERR <= CFG_LOAD && !cfg_ok_c;
            if (advance_c) begin
                h           <= W'(h_nxt_c);
                v           <= W'(v_nxt_c);
                ACTIVE      <= h_act_c && v_act_c;
                HSYNC       <= h_sync_c;
                VSYNC       <= v_sync_c;
                LINE_START  <= (h_nxt_c == '0);
                FRAME_START <= (h_nxt_c == '0) && (v_nxt_c == '0);
            end
            // A load in the apply cycle lands in pending; the old pending set goes live.
            if (apply_c) begin
                live_h <= pend_h;
                live_v <= pend_v;
            end
            if (CFG_LOAD && cfg_ok_c) begin
                pend_h      <= cfg_h_c;
                pend_v      <= cfg_v_c;
                CFG_PENDING <= 1'b1;
            end else if (apply_c) begin
                CFG_PENDING <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a frame-level reference model predicts every cycle's outputs.
module tb_video_timing_gen;

    localparam int W    = 13;
    localparam int SPAN = 1 << W;
    localparam bit HP   = 1'b0;
    localparam bit VP   = 1'b0;

    typedef struct {
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
    } cfg_t;

    typedef struct packed {
        logic         pend;
        logic         err;
        logic         hs;
        logic         vs;
        logic         act;
        logic         ls;
        logic         fs;
        logic [W-1:0] h;
        logic [W-1:0] v;
    } obs_t;

    localparam cfg_t XGA   = '{ha: 1024, hfp: 24, hs: 136, hbp: 160, va: 768, vfp: 3, vs: 6, vbp: 29};
    localparam cfg_t SMALL = '{ha: 8, hfp: 2, hs: 3, hbp: 3, va: 4, vfp: 1, vs: 2, vbp: 1};
    localparam cfg_t WIDE  = '{ha: 12, hfp: 2, hs: 3, hbp: 3, va: 4, vfp: 1, vs: 2, vbp: 1};
    localparam cfg_t NOHS  = '{ha: 8, hfp: 2, hs: 0, hbp: 3, va: 4, vfp: 1, vs: 2, vbp: 1};
    localparam cfg_t FULL  = '{ha: 8000, hfp: 100, hs: 42, hbp: 50, va: 4, vfp: 1, vs: 2, vbp: 1};
    localparam cfg_t OVER  = '{ha: 8000, hfp: 100, hs: 42, hbp: 51, va: 4, vfp: 1, vs: 2, vbp: 1};

    logic         CLK = 1'b0;
    logic         RST, CE, CFG_LOAD;
    logic [W-1:0] CFG_H_ACTIVE, CFG_H_FPORCH, CFG_H_SYNC, CFG_H_BPORCH;
    logic [W-1:0] CFG_V_ACTIVE, CFG_V_FPORCH, CFG_V_SYNC, CFG_V_BPORCH;
    logic         CFG_PENDING, CFG_ERR, HSYNC, VSYNC, ACTIVE, LINE_START, FRAME_START;
    logic [W-1:0] h, v;

    int checks   = 0;
    int failures = 0;
    obs_t exp_q[$];

    // Reference model state: running flag, position, live and pending timing.
    bit   m_run;
    int   m_h, m_v;
    cfg_t m_live, m_pend;
    bit   m_pflag;

    always #5 CLK = ~CLK;

    video_timing_gen dut (
        .CLK(CLK), .RST(RST), .CE(CE), .CFG_LOAD(CFG_LOAD),
        .CFG_H_ACTIVE(CFG_H_ACTIVE), .CFG_H_FPORCH(CFG_H_FPORCH),
        .CFG_H_SYNC(CFG_H_SYNC), .CFG_H_BPORCH(CFG_H_BPORCH),
        .CFG_V_ACTIVE(CFG_V_ACTIVE), .CFG_V_FPORCH(CFG_V_FPORCH),
        .CFG_V_SYNC(CFG_V_SYNC), .CFG_V_BPORCH(CFG_V_BPORCH),
        .CFG_PENDING(CFG_PENDING), .CFG_ERR(CFG_ERR), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .ACTIVE(ACTIVE), .LINE_START(LINE_START), .FRAME_START(FRAME_START),
        .h(h), .v(v)
    );

    function automatic int ht(input cfg_t c);
        return c.ha + c.hfp + c.hs + c.hbp;
    endfunction

    function automatic int vt(input cfg_t c);
        return c.va + c.vfp + c.vs + c.vbp;
    endfunction

    function automatic bit cfg_ok(input cfg_t c);
        return c.ha >= 1 && c.hs >= 1 && c.va >= 1 && c.vs >= 1 && ht(c) <= SPAN && vt(c) <= SPAN;
    endfunction

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.ha  = int'($urandom_range(0, 8));
        c.hfp = int'($urandom_range(0, 3));
        c.hs  = int'($urandom_range(0, 4));
        c.hbp = int'($urandom_range(0, 3));
        c.va  = int'($urandom_range(0, 5));
        c.vfp = int'($urandom_range(0, 2));
        c.vs  = int'($urandom_range(0, 3));
        c.vbp = int'($urandom_range(0, 2));
        return c;
    endfunction

    // Advance the model by one clock edge and return what the DUT should then present.
    function automatic obs_t model_step(input bit rst, input bit ce, input bit load, input cfg_t c);
        obs_t e;
        bit   app;
        bit   err = 1'b0;
        if (rst) begin
            m_run = 1'b0; m_h = 0; m_v = 0;
            m_live = XGA; m_pend = XGA; m_pflag = 1'b0;
        end else begin
            app = ce && (!m_run || (m_h == ht(m_live) - 1 && m_v == vt(m_live) - 1));
            if (ce) begin
                if (!m_run) begin
                    m_run = 1'b1; m_h = 0; m_v = 0;
                end else if (m_h == ht(m_live) - 1) begin
                    m_h = 0;
                    m_v = (m_v == vt(m_live) - 1) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
            end
            if (app) m_live = m_pend;
            if (load && cfg_ok(c)) begin
                m_pend = c; m_pflag = 1'b1;
            end else if (app) begin
                m_pflag = 1'b0;
            end
            err = load && !cfg_ok(c);
        end
        e.pend = m_pflag;
        e.err  = err;
        e.h    = W'(m_h);
        e.v    = W'(m_v);
        if (m_run) begin
            e.act = (m_h < m_live.ha) && (m_v < m_live.va);
            e.hs  = (m_h >= m_live.ha + m_live.hfp && m_h < m_live.ha + m_live.hfp + m_live.hs) ? HP : ~HP;
            e.vs  = (m_v >= m_live.va + m_live.vfp && m_v < m_live.va + m_live.vfp + m_live.vs) ? VP : ~VP;
            e.ls  = (m_h == 0);
            e.fs  = (m_h == 0) && (m_v == 0);
        end else begin
            e.act = 1'b0; e.hs = ~HP; e.vs = ~VP; e.ls = 1'b0; e.fs = 1'b0;
        end
        return e;
    endfunction

    task automatic cycle(input bit rst, input bit ce, input bit load, input cfg_t c);
        obs_t e;
        RST = rst; CE = ce; CFG_LOAD = load;
        CFG_H_ACTIVE = W'(c.ha); CFG_H_FPORCH = W'(c.hfp); CFG_H_SYNC = W'(c.hs); CFG_H_BPORCH = W'(c.hbp);
        CFG_V_ACTIVE = W'(c.va); CFG_V_FPORCH = W'(c.vfp); CFG_V_SYNC = W'(c.vs); CFG_V_BPORCH = W'(c.vbp);
        e = model_step(rst, ce, load, c);
        @(posedge CLK);
        exp_q.push_back(e);
        #1;
    endtask

    // mode 0: CE always 1; mode 1: CE toggles 1,0
    task automatic run_ce(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, (mode == 0) ? 1'b1 : ((i % 2) == 0), 1'b0, rand_cfg());
        end
    endtask

    task automatic goto_pos(input int th, input int tv);
        int n = 0;
        while (!(m_run && m_h == th && m_v == tv) && n < 4000) begin
            cycle(1'b0, 1'b1, 1'b0, rand_cfg());
            n++;
        end
        if (n >= 4000) begin
            checks++;
            failures++;
            $display("FAIL goto_pos: position (%0d,%0d) not reached, required within 4000 cycles", th, tv);
        end
    endtask

    // Monitor: each negedge compares the outputs of the preceding clock edge.
    always @(negedge CLK) begin
        obs_t got, e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{pend: CFG_PENDING, err: CFG_ERR, hs: HSYNC, vs: VSYNC, act: ACTIVE,
                    ls: LINE_START, fs: FRAME_START, h: h, v: v};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b pend=%b err=%b required h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b pend=%b err=%b",
                         $time, got.h, got.v, got.hs, got.vs, got.act, got.ls, got.fs, got.pend, got.err,
                         e.h, e.v, e.hs, e.vs, e.act, e.ls, e.fs, e.pend, e.err);
            end
        end
    end

    initial begin
        cfg_t zero = '{default: 0};
        RST = 1'b1; CE = 1'b0; CFG_LOAD = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, zero);
        cycle(1'b1, 1'b1, 1'b1, SMALL);
        cycle(1'b1, 1'b0, 1'b0, zero);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, zero);

        // stage a small mode while idle; it goes live on the first CE
        cycle(1'b0, 1'b0, 1'b1, SMALL);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, zero);
        run_ce(256, 0);
        run_ce(256, 1);

        // widen the line mid-frame; the current frame must finish at HT=16
        goto_pos(3, 2);
        cycle(1'b0, 1'b1, 1'b1, WIDE);
        run_ce(400, 0);

        cycle(1'b0, 1'b1, 1'b1, NOHS);
        run_ce(4, 0);

        // span limit: exactly 2^W accepted, one more rejected, then overwritten
        cycle(1'b0, 1'b0, 1'b1, FULL);
        cycle(1'b0, 1'b0, 1'b0, zero);
        cycle(1'b0, 1'b1, 1'b1, OVER);
        cycle(1'b0, 1'b1, 1'b1, SMALL);
        run_ce(300, 0);

        // load in the wrap cycle goes live one frame later
        goto_pos(15, 7);
        cycle(1'b0, 1'b1, 1'b1, WIDE);
        run_ce(300, 0);

        for (int i = 0; i < 2000; i++) begin
            cycle(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, rand_cfg());
        end

        cycle(1'b0, 1'b1, 1'b1, SMALL);
        run_ce(300, 0);
        goto_pos(7, 3);
        cycle(1'b1, 1'b1, 1'b1, WIDE);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, zero);
        run_ce(1400, 0);

        @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
